// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type and frame constants for the console UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int UART_DATA_BITS = 8;
  localparam logic TX_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; a push while full is taken only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic wr, rd;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = wptr_q == rptr_q;
  assign wr = push_i & (~full_o | pop_i);
  assign rd = pop_i & ~empty_o;
  assign data_o = mem_q[rptr_q[AW-1:0]];
  // pointer advance; the extra MSB tells full from empty
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
    end
  end
  // storage write; head is read combinationally so a same-cycle pop sees the old entry
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/out_byte_uart_tx.sv
// out_byte_uart_tx: buffers console bytes and serialises them as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined)
module out_byte_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_byte,
  input  logic       in_byte_en,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic [7:0] drop_count
);
  localparam int BW = $clog2(CLK_DIV);
`ifdef UART_TX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, drop_q, drop_d, f_data;
  logic tx_q, tx_d, busy_q, busy_d;
  logic f_full, f_empty, pop, push_ok, baud_end, par_bit;
  assign baud_end = baud_q == BW'(CLK_DIV - 1);
  assign pop = ~f_empty & ((state_q == IDLE) | (state_q == STOP & baud_end));
  assign push_ok = in_byte_en & (~f_full | pop);
  assign tx = tx_q;
  assign busy = busy_q;
  assign fifo_full = f_full;
  assign drop_count = drop_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push_i(in_byte_en),
    .data_i(in_byte),
    .pop_i(pop),
    .data_o(f_data),
    .full_o(f_full),
    .empty_o(f_empty)
  );
`ifdef UART_TX_PARITY_EN
  logic par_q;
  // even parity of the byte being sent, captured as it leaves the FIFO
  always_ff @(posedge clk) begin
    if (!resetn) par_q <= 1'b0;
    else if (pop) par_q <= ^f_data;
  end
  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif
  // frame sequencing, bit/baud counting, shifting, drop accounting and registered outputs
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    case (state_q)
      IDLE:    if (!f_empty) state_d = START;
      START:   if (baud_end) state_d = DATA;
      DATA: if (baud_end) begin
        bit_d = bit_q + 3'd1;
        sh_d = sh_q >> 1;
        if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = AFTER_DATA;
      end
      PARITY:  if (baud_end) state_d = STOP;
      STOP:    if (baud_end) state_d = f_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
    if (pop) sh_d = f_data;
    baud_d = (state_d != state_q || state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_bit : TX_IDLE_LEVEL;
    busy_d = (state_d != IDLE) | ~f_empty | push_ok;
    drop_d = (in_byte_en & f_full & ~pop & drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  // state register; reset aborts any frame in flight and returns the line to idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      drop_q <= '0;
      tx_q <= TX_IDLE_LEVEL;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      drop_q <= drop_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_out_byte_uart_tx.sv
// tb_out_byte_uart_tx: directed bench for out_byte_uart_tx at CLK_DIV=4, FIFO_DEPTH=4 (parity scenario under UART_TX_PARITY_EN)
module tb_out_byte_uart_tx;
  localparam int DIV = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_byte_en = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic tx, busy, fifo_full;
  logic [7:0] drop_count;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  out_byte_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEP)) dut (
    .clk(clk),
    .resetn(resetn),
    .in_byte(in_byte),
    .in_byte_en(in_byte_en),
    .tx(tx),
    .busy(busy),
    .fifo_full(fifo_full),
    .drop_count(drop_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b01, d, 1'b0};
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    in_byte_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic get_frame(output logic [10:0] f, output logic [43:0] raw);
    f = '0;
    raw = '0;
    for (int i = 0; i < NB * DIV; i++) begin
      @(negedge clk);
      raw[i] = tx;
      if (i % DIV == 1) f[i / DIV] = tx;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    in_byte_en = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    logic [10:0] f, ef;
    logic [43:0] raw, er;
    ef = exp_frame(8'hA5);
    er = '0;
    for (int i = 0; i < NB * DIV; i++) er[i] = ef[i / DIV];
    @(negedge clk);
    in_byte = 8'hA5;
    in_byte_en = 1'b1;
    @(negedge clk);
    in_byte_en = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_latency_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_early got=%b exp=1", busy); end
    get_frame(f, raw);
    checks++; if (raw !== er) begin failures++; $display("FAIL single_wave got=%h exp=%h", raw, er); end
    checks++; if (f !== ef) begin failures++; $display("FAIL single_frame got=%h exp=%h", f, ef); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_last got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_idle got=%b exp=1", tx); end
    checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL single_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f [3];
    logic [43:0] r;
    do_reset();
    @(negedge clk);
    in_byte_en = 1'b1;
    in_byte = 8'h41;
    @(negedge clk);
    in_byte = 8'h42;
    fork
      begin
        @(negedge clk);
        in_byte = 8'h43;
        @(negedge clk);
        in_byte_en = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) get_frame(f[k], r);
      end
    join
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (f[k] !== exp_frame(8'(8'h41 + k))) begin
        failures++;
        $display("FAIL b2b_frame%0d got=%h exp=%h", k, f[k], exp_frame(8'(8'h41 + k)));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    logic [10:0] f [5];
    logic [43:0] r;
    logic full_seen;
    full_seen = 1'b0;
    do_reset();
    @(negedge clk);
    in_byte_en = 1'b1;
    in_byte = 8'h10;
    @(negedge clk);
    in_byte = 8'h11;
    fork
      begin
        for (int j = 2; j < 7; j++) begin
          @(negedge clk);
          if (j == 5) full_seen = fifo_full;
          in_byte = 8'(8'h10 + j);
        end
        @(negedge clk);
        in_byte_en = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) get_frame(f[k], r);
      end
    join
    checks++; if (full_seen !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full_seen); end
    checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (f[k] !== exp_frame(8'(8'h10 + k))) begin
        failures++;
        $display("FAIL ovf_frame%0d got=%h exp=%h", k, f[k], exp_frame(8'(8'h10 + k)));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_end got=%b exp=0", busy); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL ovf_full_end got=%b exp=0", fifo_full); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < 304; i++) begin
      @(negedge clk);
      if (i == 10) begin
        checks++; if (drop_count !== 8'd5) begin failures++; $display("FAIL sat_drop_early got=%0d exp=5", drop_count); end
      end
      in_byte_en = 1'b1;
      in_byte = 8'(i);
    end
    @(negedge clk);
    in_byte_en = 1'b0;
    checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL sat_drop got=%0d exp=255", drop_count); end
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL sat_full got=%b exp=1", fifo_full); end
  endtask

  task automatic test_reset_midframe();
    logic bad;
    bad = 1'b0;
    do_reset();
    @(negedge clk);
    in_byte_en = 1'b1;
    in_byte = 8'hF0;
    @(negedge clk);
    in_byte = 8'h0F;
    @(negedge clk);
    in_byte = 8'h55;
    @(negedge clk);
    in_byte_en = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_bit3 got=%b exp=0", tx); end
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", fifo_full); end
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL mid_quiet got=%b exp=0", bad); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] f;
    logic [43:0] r;
    do_reset();
    @(negedge clk);
    in_byte_en = 1'b1;
    in_byte = 8'h07;
    @(negedge clk);
    in_byte_en = 1'b0;
    get_frame(f, r);
    checks++; if (f[9] !== 1'b1) begin failures++; $display("FAIL par07_bit got=%b exp=1", f[9]); end
    checks++; if (f !== exp_frame(8'h07)) begin failures++; $display("FAIL par07_frame got=%h exp=%h", f, exp_frame(8'h07)); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL par07_busy_last got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL par07_busy_end got=%b exp=0", busy); end
    @(negedge clk);
    in_byte_en = 1'b1;
    in_byte = 8'h03;
    @(negedge clk);
    in_byte_en = 1'b0;
    get_frame(f, r);
    checks++; if (f[9] !== 1'b0) begin failures++; $display("FAIL par03_bit got=%b exp=0", f[9]); end
    checks++; if (f !== exp_frame(8'h03)) begin failures++; $display("FAIL par03_frame got=%h exp=%h", f, exp_frame(8'h03)); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_drop_saturate();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
